vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, SHALL set the number of consecutive CPU losses to video before the CPU is forced a grant; legal range 1..15.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 cpu_addr  input  16  CPU byte address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_ack  output  1  combinational; high in the cycle the CPU access is issued to RAM.
REQ-009 cpu_rdata  output  8  registered CPU read data.
REQ-010 cpu_rvalid  output  1  registered one-cycle pulse; cpu_rdata valid.
REQ-011 vid_req  input  1  video read request; held until vid_ack.
REQ-012 vid_addr  input  16  video read address.
REQ-013 vid_ack  output  1  combinational; high in the cycle the video read is issued.
REQ-014 vid_rdata  output  8  registered video read data.
REQ-015 vid_rvalid  output  1  registered one-cycle pulse; vid_rdata valid.
REQ-016 ram_addr  output  16  to 64K x 8 RAM address.
REQ-017 ram_wdata  output  8  to RAM write data.
REQ-018 ram_we  output  1  to RAM write enable.
REQ-019 ram_rdata  input  8  from RAM; valid the cycle after the address is presented.

Function
REQ-020 Exactly one access SHALL be issued per cycle at most; cpu_ack and vid_ack SHALL never both be high.
REQ-021 Grant: vid_req only -> video; cpu_req only -> CPU; both -> video, unless starve_cnt == STARVE_LIMIT, then CPU.
REQ-022 starve_cnt (4-bit) SHALL increment when cpu_req and vid_req are both high and video is granted; it SHALL clear to 0 when the CPU is granted or cpu_req is low; it SHALL never exceed STARVE_LIMIT.
REQ-023 Video grant: ram_addr = vid_addr, ram_we = 0.
REQ-024 CPU grant: ram_addr = cpu_addr, ram_wdata = cpu_wdata, ram_we = cpu_we.
REQ-025 No grant: ram_addr = 16'h0000, ram_wdata = 8'h00, ram_we = 0.
REQ-026 ram_wdata SHALL be 8'h00 whenever ram_we is 0.
REQ-027 A read issued in cycle N SHALL produce its rvalid pulse in cycle N+2, with rdata equal to ram_rdata sampled at the end of cycle N+1.
REQ-028 A two-stage tag pipeline (none/cpu/vid) SHALL route each return; back-to-back reads in consecutive cycles SHALL each return in order, one per cycle, with no loss.
REQ-029 CPU writes SHALL produce no cpu_rvalid.
REQ-030 rdata registers SHALL hold their last value when the corresponding rvalid is low.
REQ-031 A CPU write followed in the next cycle by a CPU read of the same address SHALL return the newly written data; RAM write-then-read ordering is sufficient, and no bypass SHALL be added.
REQ-032 vid_ack and cpu_ack SHALL be 0 whenever reset_n is low.

Reset
REQ-033 While reset_n is low at a rising edge: starve_cnt = 0, both tag stages = none, cpu_rvalid = vid_rvalid = 0, cpu_rdata = vid_rdata = 8'h00.
REQ-034 While reset_n is low, ram_we SHALL be 0 and no grant SHALL be issued, regardless of requests.
REQ-035 Reads in flight when reset asserts SHALL be discarded: no rvalid pulse after reset, even if reset lasts only one cycle.

Verification
REQ-036 CPU write 0x1234 <- 0xA5, then CPU read 0x1234 -> cpu_ack in both cycles; cpu_rvalid two cycles after the read ack with cpu_rdata = 0xA5; ram_we high only in the write cycle.
REQ-037 vid_req and cpu_req (read) both held high, STARVE_LIMIT = 3 -> vid_ack for 3 cycles, cpu_ack in the 4th, then video again; starve_cnt sequence 0,1,2,3,0.
REQ-038 Video reads of 0x8000, 0x8001 and 0x0000 in consecutive cycles (RAM preloaded with 0x11, 0x22, 0x33) -> vid_rvalid on three consecutive cycles, returning 0x11, 0x22, 0x33 in order.
REQ-039 Interleaved: video read of 0x0010 in cycle N, CPU read of 0x0020 in cycle N+1 -> vid_rvalid in N+2 and cpu_rvalid in N+3, each with the correct data and no cross-routing.
REQ-040 Issue a CPU read, assert reset_n = 0 for one cycle in the following cycle -> no cpu_rvalid ever appears; all outputs at reset values; the next request behaves normally.
REQ-041 cpu_req high, vid_req low, with a CPU write held high for one cycle -> immediate cpu_ack, starve_cnt stays 0, and no rvalid appears.

Source files
------------

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares one 64K x 8 synchronous RAM between a CPU port and a video read
//   port. At most one access is issued per cycle. Video normally wins a
//   collision. After STARVE_LIMIT consecutive CPU losses, the CPU is forced
//   a grant. Read data returns two cycles after issue. A two-stage tag
//   pipeline steers each return to the port that issued the read.
//
// Parameters
//   STARVE_LIMIT  consecutive CPU losses before a forced CPU grant (1..15)
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request (held until cpu_ack)
//   cpu_ack                      combinational; CPU access issued this cycle
//   cpu_rdata/cpu_rvalid         registered CPU read return
//   vid_req/vid_addr             video read request (held until vid_ack)
//   vid_ack                      combinational; video read issued this cycle
//   vid_rdata/vid_rvalid         registered video read return
//   ram_addr/wdata/we            RAM command, driven in the issue cycle
//   ram_rdata                    RAM data, valid the cycle after the address
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  output logic        vid_rvalid,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VID  = 2'd2
  } tag_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  tag_e       tag1_q, tag1_d;   // read issued last cycle; RAM data valid now
  tag_e       tag2_q, tag2_d;   // read whose data sits in an rdata register
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] vid_rdata_q, vid_rdata_d;

  logic starve_hit;
  logic grant_cpu;
  logic grant_vid;

  // Grant decision. reset_n gates both grants so nothing reaches the RAM
  // while reset is asserted, whatever the requesters do.
  always_comb begin
    starve_hit = (starve_q == LIMIT);
    grant_cpu  = reset_n & cpu_req & (~vid_req | starve_hit);
    grant_vid  = reset_n & vid_req & ~grant_cpu;
  end

  // RAM command mux. Write data is forced to zero unless a write is issued.
  always_comb begin
    ram_addr  = 16'h0000;
    ram_wdata = 8'h00;
    ram_we    = 1'b0;
    if (grant_vid) begin
      ram_addr = vid_addr;
    end else if (grant_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (cpu_we) begin
        ram_wdata = cpu_wdata;
      end
    end
  end

  always_comb begin
    // Count only collisions that video wins. A CPU grant or an idle CPU
    // clears the count. The count cannot pass LIMIT because reaching it
    // forces the CPU grant.
    starve_d = 4'd0;
    if (grant_vid && cpu_req) begin
      starve_d = 4'(starve_q + 4'd1);
    end

    tag1_d = TAG_NONE;
    if (grant_vid) begin
      tag1_d = TAG_VID;
    end else if (grant_cpu && !cpu_we) begin
      tag1_d = TAG_CPU;
    end
    tag2_d = tag1_q;

    // Capture RAM data for the read issued last cycle. Otherwise hold.
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    if (tag1_q == TAG_CPU) begin
      cpu_rdata_d = ram_rdata;
    end
    if (tag1_q == TAG_VID) begin
      vid_rdata_d = ram_rdata;
    end
  end

  // Clearing both tag stages on reset drops every read in flight, even for a
  // one-cycle reset pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q    <= 4'd0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      cpu_rdata_q <= 8'h00;
      vid_rdata_q <= 8'h00;
    end else begin
      starve_q    <= starve_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign cpu_ack    = grant_cpu;
  assign vid_ack    = grant_vid;
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rdata  = vid_rdata_q;
  // The valid strobes are decoded directly from the second tag stage flops.
  assign cpu_rvalid = (tag2_q == TAG_CPU);
  assign vid_rvalid = (tag2_q == TAG_VID);

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//   Directed scenarios followed by a randomized phase. The bench provides a
//   behavioural 64K x 8 RAM. A reference model predicts grants, RAM commands
//   and read returns. It keeps a shadow memory image and a queue of
//   (due cycle, port, data) return entries.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        vid_rvalid;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External synchronous RAM with read-first behaviour.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    bit         is_cpu;
    logic [7:0] data;
  } ret_t;

  ret_t       pend[$];
  logic [7:0] exp_mem [0:65535];
  int         starve_m;
  logic [7:0] exp_cpu_rd, exp_vid_rd;
  int         cyc;
  bit         last_g_cpu, last_g_vid;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Drives one cycle of stimulus, checks every output against the model,
  // and then advances the model across the rising edge.
  task automatic step(input logic rst, input logic creq, input logic cwe,
                      input logic [15:0] caddr, input logic [7:0] cwd,
                      input logic vreq, input logic [15:0] vaddr);
    bit g_cpu, g_vid, ev_c, ev_v;
    logic [15:0] e_addr;
    @(negedge clk);
    reset_n = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr;
    cpu_wdata = cwd; vid_req = vreq; vid_addr = vaddr;
    #1;
    // Video wins a collision unless the CPU has already lost LIMIT times.
    g_cpu = rst && creq && (!vreq || starve_m == LIMIT);
    g_vid = rst && vreq && !g_cpu;
    e_addr = g_vid ? vaddr : (g_cpu ? caddr : 16'h0000);
    check("cpu_ack", 32'(cpu_ack), 32'(g_cpu));
    check("vid_ack", 32'(vid_ack), 32'(g_vid));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_we", 32'(ram_we), 32'(g_cpu && cwe));
    check("ram_wdata", 32'(ram_wdata), 32'((g_cpu && cwe) ? cwd : 8'h00));
    check("starve_cnt", 32'(dut.starve_q), 32'(starve_m));
    ev_c = 0; ev_v = 0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        if (pend[i].is_cpu) begin ev_c = 1; exp_cpu_rd = pend[i].data; end
        else begin ev_v = 1; exp_vid_rd = pend[i].data; end
        pend.delete(i);
      end
    end
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(ev_c));
    check("vid_rvalid", 32'(vid_rvalid), 32'(ev_v));
    check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
    check("vid_rdata", 32'(vid_rdata), 32'(exp_vid_rd));
    $display("cyc=%0d rst_n=%b creq=%b we=%b ca=%h vreq=%b va=%h ack_c=%b ack_v=%b rv_c=%b/%h rv_v=%b/%h",
             cyc, rst, creq, cwe, caddr, vreq, vaddr, cpu_ack, vid_ack,
             cpu_rvalid, cpu_rdata, vid_rvalid, vid_rdata);
    @(posedge clk);
    if (!rst) begin
      pend.delete();
      starve_m   = 0;
      exp_cpu_rd = 8'h00;
      exp_vid_rd = 8'h00;
    end else begin
      if (g_cpu && cwe) exp_mem[caddr] = cwd;
      if (g_cpu && !cwe) pend.push_back('{cyc + 2, 1'b1, exp_mem[caddr]});
      if (g_vid)         pend.push_back('{cyc + 2, 1'b0, exp_mem[vaddr]});
      if (creq && vreq && g_vid) starve_m = starve_m + 1;
      else                       starve_m = 0;
    end
    last_g_cpu = g_cpu;
    last_g_vid = g_vid;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 8'h0, 0, 16'h0);
  endtask

  task automatic cwrite(input logic [15:0] a, input logic [7:0] d);
    step(1, 1, 1, a, d, 0, 16'h0);
  endtask

  logic        cp_req, cp_we, vp_req, rr;
  logic [15:0] cp_addr, vp_addr;
  logic [7:0]  cp_wd;

  initial begin
    cyc = 0; starve_m = 0; exp_cpu_rd = 8'h00; exp_vid_rd = 8'h00;
    reset_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_addr = 0;

    // Reset with both requesters active: no grant, no write.
    step(0, 1, 1, 16'h1111, 8'hFF, 1, 16'h2222);
    step(0, 1, 1, 16'h1111, 8'hFF, 1, 16'h2222);
    step(0, 0, 0, 16'h0, 8'h0, 0, 16'h0);

    // Write 0x1234 <- A5, then read it back the following cycle.
    cwrite(16'h1234, 8'hA5);
    step(1, 1, 0, 16'h1234, 8'h00, 0, 16'h0);
    idle(3);

    // Load the memory image for the later scenarios and the random window.
    cwrite(16'h8000, 8'h11);
    cwrite(16'h8001, 8'h22);
    cwrite(16'h0000, 8'h33);
    cwrite(16'h0010, 8'h5C);
    cwrite(16'h0020, 8'hC3);
    for (int i = 0; i < 16; i++) cwrite(16'h4000 + 16'(i), 8'($urandom));

    // Back-to-back video reads return in order, one per cycle.
    step(1, 0, 0, 16'h0, 8'h0, 1, 16'h8000);
    step(1, 0, 0, 16'h0, 8'h0, 1, 16'h8001);
    step(1, 0, 0, 16'h0, 8'h0, 1, 16'h0000);
    idle(3);

    // A video read followed by a CPU read must not be cross-routed.
    step(1, 0, 0, 16'h0, 8'h0, 1, 16'h0010);
    step(1, 1, 0, 16'h0020, 8'h0, 0, 16'h0);
    idle(3);

    // Starvation: video takes three collisions, then the CPU wins the fourth.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h1234, 8'h0, 1, 16'h8000);
    step(1, 0, 0, 16'h0, 8'h0, 1, 16'h8001);
    idle(3);

    // A one-cycle reset drops the CPU read in flight.
    step(1, 1, 0, 16'h1234, 8'h0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 8'h0, 0, 16'h0);
    idle(3);
    step(1, 1, 0, 16'h8001, 8'h0, 0, 16'h0);
    idle(3);

    // A lone CPU write is acked immediately and returns no data.
    cwrite(16'h0020, 8'h7E);
    idle(3);

    // Random phase. Each requester holds its request until the model grants it.
    cp_req = 0; vp_req = 0; cp_we = 0; cp_addr = 0; cp_wd = 0; vp_addr = 0;
    for (int n = 0; n < 600; n++) begin
      if (!cp_req && $urandom_range(0, 99) < 60) begin
        cp_req  = 1;
        cp_we   = $urandom_range(0, 2) == 0;
        cp_addr = 16'h4000 + 16'($urandom_range(0, 15));
        cp_wd   = 8'($urandom);
      end
      if (!vp_req && $urandom_range(0, 99) < 75) begin
        vp_req  = 1;
        vp_addr = 16'h4000 + 16'($urandom_range(0, 15));
      end
      rr = ($urandom_range(0, 49) != 0);
      step(rr, cp_req, cp_req & cp_we, cp_req ? cp_addr : 16'h0,
           cp_req ? cp_wd : 8'h0, vp_req, vp_req ? vp_addr : 16'h0);
      if (last_g_cpu || !rr) cp_req = 0;
      if (last_g_vid || !rr) vp_req = 0;
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
